// File: rtl/bcd_alu.sv
// Four-digit packed-BCD add/subtract/nine's-complement/compare unit.
// Results are binary. There is one output register, so results appear one clock after the operands.
module bcd_alu #(
  parameter logic [15:0] ERR_CODE = 16'hCCCC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  OP,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] C,
  output logic        out_valid
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NINE = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  localparam logic [15:0] MAX_BCD_BIN = 16'd9999;

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  function automatic logic bcd_ok(input logic [15:0] v);
    return digit_ok(v[15:12]) && digit_ok(v[11:8]) &&
           digit_ok(v[7:4])   && digit_ok(v[3:0]);
  endfunction

  // Weighted digit sum; the result is at most 9999, so 16 bits hold every intermediate value.
  function automatic logic [15:0] bcd_to_bin(input logic [15:0] v);
    logic [15:0] d3, d2, d1, d0;
    d3 = {12'd0, v[15:12]};
    d2 = {12'd0, v[11:8]};
    d1 = {12'd0, v[7:4]};
    d0 = {12'd0, v[3:0]};
    return (d3 * 16'd1000) + (d2 * 16'd100) + (d1 * 16'd10) + d0;
  endfunction

  logic [15:0] a_bin;
  logic [15:0] b_bin;
  logic        operands_ok;
  logic [15:0] add_res;
  logic [15:0] sub_res;
  logic [15:0] nine_res;
  logic [15:0] cmp_res;
  logic [15:0] result;

  assign a_bin       = bcd_to_bin(A);
  assign b_bin       = bcd_to_bin(B);
  assign operands_ok = bcd_ok(A) && bcd_ok(B);

  // Both operands are at most 9999, so the 16-bit wraparound of the difference is its two's complement value.
  assign add_res  = a_bin + b_bin;
  assign sub_res  = a_bin - b_bin;
  assign nine_res = MAX_BCD_BIN - a_bin;

  always_comb begin
    cmp_res = 16'h0000;
    if (a_bin > b_bin)
      cmp_res = 16'h0001;
    else if (a_bin < b_bin)
      cmp_res = 16'hFFFF;
  end

  always_comb begin
    result = ERR_CODE;
    if (operands_ok) begin
      unique case (OP)
        OP_ADD:  result = add_res;
        OP_SUB:  result = sub_res;
        OP_NINE: result = nine_res;
        OP_CMP:  result = cmp_res;
        default: result = ERR_CODE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C         <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        C <= result;
    end
  end

endmodule

// File: tb/tb_bcd_alu.sv
// Directed testbench for bcd_alu. Inputs are driven on the falling edge and outputs are checked 1 ns after the rising edge.
module tb_bcd_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  OP;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .OP        (OP),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    OP = op;
    A  = a;
    B  = b;
    @(posedge clk);
    #1;
    check(tag, C, exp);
    check({tag, "_vld"}, {15'd0, out_valid}, 16'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    OP       = 2'b00;
    A        = 16'h0000;
    B        = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c", C, 16'h0000);
    check("rst_vld", {15'd0, out_valid}, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    A = 16'h1234;
    @(posedge clk);
    #1;
    check("idle_c", C, 16'h0000);
    check("idle_vld", {15'd0, out_valid}, 16'd0);

    apply("add_6_63",    2'b00, 16'h0006, 16'h0063, 16'h0045);
    apply("add_max",     2'b00, 16'h9999, 16'h9999, 16'd19998);
    apply("add_1234",    2'b00, 16'h1234, 16'h8765, 16'd9999);
    apply("sub_neg",     2'b01, 16'h0007, 16'h0023, 16'hFFF0);
    apply("sub_pos",     2'b01, 16'h0023, 16'h0007, 16'h0010);
    apply("sub_min",     2'b01, 16'h0000, 16'h9999, 16'hD8F1);
    apply("nine_13",     2'b10, 16'h0013, 16'h0023, 16'd9986);
    apply("nine_0",      2'b10, 16'h0000, 16'h0000, 16'd9999);
    apply("nine_9999",   2'b10, 16'h9999, 16'h0000, 16'h0000);
    apply("err_nine_a",  2'b10, 16'hFFFF, 16'h0023, 16'hCCCC);
    apply("err_add_b",   2'b00, 16'h0012, 16'h00A1, 16'hCCCC);
    apply("err_nine_b",  2'b10, 16'h0012, 16'h0A00, 16'hCCCC);
    apply("err_cmp_a",   2'b11, 16'h1A00, 16'h0001, 16'hCCCC);
    apply("cmp_gt",      2'b11, 16'h0651, 16'h0650, 16'h0001);
    apply("cmp_eq",      2'b11, 16'h0651, 16'h0651, 16'h0000);
    apply("cmp_lt",      2'b11, 16'h0651, 16'h0652, 16'hFFFF);
    apply("cmp_decimal", 2'b11, 16'h1000, 16'h0999, 16'h0001);
    apply("sub_zero",    2'b01, 16'h4321, 16'h4321, 16'h0000);

    @(negedge clk);
    in_valid = 1'b0;
    OP = 2'b00;
    A  = 16'h0001;
    B  = 16'h0001;
    @(posedge clk);
    #1;
    check("hold_c", C, 16'h0000);
    check("hold_vld", {15'd0, out_valid}, 16'd0);

    apply("pre_rst", 2'b00, 16'h0100, 16'h0023, 16'd123);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_c", C, 16'h0000);
    check("mid_rst_vld", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_c", C, 16'h0000);

    apply("post_rst_add", 2'b00, 16'h0050, 16'h0050, 16'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
